// File: rtl/muldiv_ctrl_if.sv
// Decode-side bundle for the HI/LO multiply/divide unit: op issue, mfhi/mflo hold,
// and the stall/busy/done/HI/LO results returned to the pipeline.
interface muldiv_ctrl_if;
    logic        issue;
    logic [3:0]  mul_func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        read_req;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // Handshake: an op is taken on a rising edge when issue=1 with a valid
    // mul_func and stall=0; while stall=1 decode must hold issue/func/operands.
    modport master (
        output issue, mul_func, op_a, op_b, read_req,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  issue, mul_func, op_a, op_b, read_req,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide controller with MADD/MSUB accumulate.
// Optional feature: define MULDIV_CANCEL_EN to add a cancel_i abort input.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic         clk,
    input  logic         rst,
`ifdef MULDIV_CANCEL_EN
    input  logic         cancel_i,
`endif
    muldiv_ctrl_if.slave bus,
    output logic         dbg_state_o
);
    localparam logic [3:0] F_MULT  = 4'd1;
    localparam logic [3:0] F_MULTU = 4'd2;
    localparam logic [3:0] F_DIV   = 4'd3;
    localparam logic [3:0] F_DIVU  = 4'd4;
    localparam logic [3:0] F_SETHI = 4'd5;
    localparam logic [3:0] F_SETLO = 4'd6;
    localparam logic [3:0] F_MADD  = 4'd7;
    localparam logic [3:0] F_MADDU = 4'd8;
    localparam logic [3:0] F_MSUB  = 4'd9;
    localparam logic [3:0] F_MSUBU = 4'd10;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  func_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        op_valid;
    logic        cancel_w;

`ifdef MULDIV_CANCEL_EN
    assign cancel_w = cancel_i;
`else
    assign cancel_w = 1'b0;
`endif

    assign op_valid = bus.issue && (bus.mul_func >= F_MULT) && (bus.mul_func <= F_MSUBU);

    assign bus.busy    = (state_q == BUSY);
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.stall   = (state_q == BUSY) && (op_valid || bus.read_req);
    assign dbg_state_o = state_q;

    // Result datapath, evaluated from latched operands and the live HI/LO.
    logic        signed_op;
    logic        neg_a, neg_b;
    logic [63:0] ext_a, ext_b, prod, acc, res;
    logic [31:0] mag_a, mag_b, quo_mag, rem_mag, quo, rem;

    always_comb begin
        signed_op = (func_q == F_MULT) || (func_q == F_DIV) ||
                    (func_q == F_MADD) || (func_q == F_MSUB);
        ext_a = signed_op ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b = signed_op ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod  = ext_a * ext_b;
        acc   = {hi_q, lo_q};

        // Divide on magnitudes; 0x80000000 has magnitude 2^31, so the
        // overflow case falls out as quotient 0x80000000, remainder 0.
        neg_a   = signed_op && a_q[31];
        neg_b   = signed_op && b_q[31];
        mag_a   = neg_a ? -a_q : a_q;
        mag_b   = neg_b ? -b_q : b_q;
        quo_mag = (b_q == 32'd0) ? 32'd0 : mag_a / mag_b;
        rem_mag = (b_q == 32'd0) ? 32'd0 : mag_a % mag_b;
        quo     = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
        rem     = neg_a ? -rem_mag : rem_mag;

        res = acc;
        case (func_q)
            F_MULT, F_MULTU: res = prod;
            F_MADD, F_MADDU: res = acc + prod;
            F_MSUB, F_MSUBU: res = acc - prod;
            F_DIV, F_DIVU: begin
                if (b_q == 32'd0) res = {a_q, 32'hFFFF_FFFF};
                else              res = {rem, quo};
            end
            default: res = acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            func_q  <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op_valid && !cancel_w) begin
                        case (bus.mul_func)
                            F_SETHI: hi_q <= bus.op_a;
                            F_SETLO: lo_q <= bus.op_a;
                            default: begin
                                a_q     <= bus.op_a;
                                b_q     <= bus.op_b;
                                func_q  <= bus.mul_func;
                                cnt_q   <= ((bus.mul_func == F_DIV) || (bus.mul_func == F_DIVU))
                                           ? DIV_LOAD : MUL_LOAD;
                                state_q <= BUSY;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    if (cancel_w) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        hi_q    <= res[63:32];
                        lo_q    <= res[31:0];
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, hand-written stall/reset sequences,
// and randomized ops checked against an arithmetic model of HI/LO.
module tb_muldiv_ctrl;
    localparam int MUL_CYCLES = 5;
    localparam int DIV_CYCLES = 10;

    logic clk;
    logic rst;
    logic dbg_state;
`ifdef MULDIV_CANCEL_EN
    logic cancel;
`endif

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MULDIV_CANCEL_EN
        .cancel_i    (cancel),
`endif
        .bus         (bus.master),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] pre_hi, pre_lo, a, b, exp_hi, exp_lo;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_cycles(input logic [3:0] f);
        case (f)
            4'd3, 4'd4: return DIV_CYCLES;
            4'd5, 4'd6: return 0;
            default:    return MUL_CYCLES;
        endcase
    endfunction

    // Architectural meaning of each function, in plain 64-bit arithmetic.
    function automatic void model_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] h, inout logic [31:0] l);
        longint      sa, sb, sq, sr;
        logic [63:0] sp, up, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sp  = 64'(sa * sb);
        up  = {32'd0, a} * {32'd0, b};
        acc = {h, l};
        case (f)
            4'd1: {h, l} = sp;
            4'd2: {h, l} = up;
            4'd3, 4'd4: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else if (f == 4'd3) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    l  = sq[31:0];
                    h  = sr[31:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            4'd5: h = a;
            4'd6: l = a;
            4'd7: {h, l} = acc + sp;
            4'd8: {h, l} = acc + up;
            4'd9: {h, l} = acc - sp;
            4'd10: {h, l} = acc - up;
            default: ;
        endcase
    endfunction

    // Present one op from mid-cycle, count busy cycles, then check results and done.
    task automatic run_op(input string name, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        int ec;
        ec = exp_cycles(f);
        bus.issue    = 1'b1;
        bus.mul_func = f;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk); #1;
        bus.issue    = 1'b0;
        bus.mul_func = 4'd0;
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            cyc++;
            @(posedge clk); #1;
        end
        check($sformatf("%s_cycles", name), 32'(cyc), 32'(ec));
        check($sformatf("%s_hi", name), bus.hi, eh);
        check($sformatf("%s_lo", name), bus.lo, el);
        check($sformatf("%s_done", name), 32'(bus.done), 32'(ec != 0));
        @(posedge clk); #1;
        check($sformatf("%s_done_clr", name), 32'(bus.done), 32'd0);
    endtask

    task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
        run_op("pre_hi", 4'd5, h, 32'd0, h, m_lo);
        m_hi = h;
        run_op("pre_lo", 4'd6, l, 32'd0, m_hi, l);
        m_lo = l;
    endtask

    initial begin
        logic [31:0] eh, el, lo_before, x_val;
        logic [3:0]  f;
        logic [31:0] a, b;
        int          guard;

        vecs[0]  = '{4'd1,  32'h0,  32'h0,          32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{4'd2,  32'h0,  32'h0,          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{4'd3,  32'h0,  32'h0,          32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{4'd4,  32'h0,  32'h0,          32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[4]  = '{4'd3,  32'h0,  32'h0,          32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5]  = '{4'd8,  32'h0,  32'hFFFF_FFFF,  32'd1,         32'd1,         32'd1,         32'd0};
        vecs[6]  = '{4'd9,  32'h0,  32'h0,          32'd1,         32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7]  = '{4'd7,  32'h0,  32'd5,          32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[8]  = '{4'd3,  32'h0,  32'h0,          32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{4'd10, 32'd1,  32'h0,          32'd1,         32'd1,         32'd0,         32'hFFFF_FFFF};
        vecs[10] = '{4'd3,  32'h0,  32'h0,          32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF};

        rst          = 1'b0;
        bus.issue    = 1'b0;
        bus.mul_func = 4'd0;
        bus.op_a     = 32'd0;
        bus.op_b     = 32'd0;
        bus.read_req = 1'b0;
`ifdef MULDIV_CANCEL_EN
        cancel       = 1'b0;
`endif
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Reserved/none functions and issue=0 must not start anything.
        bus.issue = 1'b1; bus.mul_func = 4'd0; bus.op_a = 32'h1234;
        @(posedge clk); #1;
        check("ign_f0_busy", 32'(bus.busy), 32'd0);
        bus.mul_func = 4'd11;
        @(posedge clk); #1;
        check("ign_f11_busy", 32'(bus.busy), 32'd0);
        bus.mul_func = 4'd15;
        @(posedge clk); #1;
        check("ign_f15_busy", 32'(bus.busy), 32'd0);
        bus.issue = 1'b0; bus.mul_func = 4'd5;
        @(posedge clk); #1;
        check("ign_noissue_hi", bus.hi, 32'd0);
        bus.mul_func = 4'd0;

        for (int i = 0; i < 11; i++) begin
            load_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo);
            m_hi = vecs[i].exp_hi;
            m_lo = vecs[i].exp_lo;
        end

        // Idle stall is low even with a valid op presented; busy stall with read_req.
        bus.issue = 1'b1; bus.mul_func = 4'd1; bus.op_a = 32'd3; bus.op_b = 32'd4;
        #1;
        check("idle_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.issue = 1'b0; bus.mul_func = 4'd0;
        check("busy_state", 32'(dbg_state), 32'd1);
        eh = m_hi; el = m_lo;
        model_op(4'd1, 32'd3, 32'd4, eh, el);
        @(posedge clk); #1;
        bus.read_req = 1'b1;
        #1;
        guard = 0;
        while (bus.busy && guard < 20) begin
            check("rd_stall_busy", 32'(bus.stall), 32'd1);
            guard++;
            @(posedge clk); #1;
        end
        check("rd_stall_after", 32'(bus.stall), 32'd0);
        check("rd_lo", bus.lo, el);
        bus.read_req = 1'b0;
        m_hi = eh; m_lo = el;
        @(posedge clk); #1;

        // SETLO held while busy: lo untouched until the IDLE cycle after commit.
        lo_before = m_lo;
        x_val = 32'hCAFE_0123;
        eh = m_hi; el = m_lo;
        model_op(4'd2, 32'd6, 32'd7, eh, el);
        bus.issue = 1'b1; bus.mul_func = 4'd2; bus.op_a = 32'd6; bus.op_b = 32'd7;
        @(posedge clk); #1;
        bus.mul_func = 4'd6; bus.op_a = x_val;
        guard = 0;
        while (bus.busy && guard < 20) begin
            check("setlo_stall", 32'(bus.stall), 32'd1);
            check("setlo_lo_hold", bus.lo, lo_before);
            guard++;
            @(posedge clk); #1;
        end
        check("setlo_commit_lo", bus.lo, el);
        check("setlo_idle_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.issue = 1'b0; bus.mul_func = 4'd0;
        check("setlo_taken", bus.lo, x_val);
        check("setlo_not_busy", 32'(bus.busy), 32'd0);
        m_hi = eh; m_lo = x_val;

        // Asynchronous reset in the middle of a divide.
        bus.issue = 1'b1; bus.mul_func = 4'd3; bus.op_a = 32'd100; bus.op_b = 32'd3;
        @(posedge clk); #1;
        bus.issue = 1'b0; bus.mul_func = 4'd0;
        repeat (3) begin @(posedge clk); #1; end
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_hi", bus.hi, 32'd0);
        check("mid_rst_lo", bus.lo, 32'd0);
        #1 rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        run_op("post_rst", 4'd1, 32'd2, 32'd3, 32'd0, 32'd6);
        m_lo = 32'd6;

`ifdef MULDIV_CANCEL_EN
        // Cancel on the commit edge discards the result and the done pulse.
        bus.issue = 1'b1; bus.mul_func = 4'd3; bus.op_a = 32'd50; bus.op_b = 32'd7;
        @(posedge clk); #1;
        bus.issue = 1'b0; bus.mul_func = 4'd0;
        repeat (DIV_CYCLES - 1) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_busy", 32'(bus.busy), 32'd0);
        check("cancel_done", 32'(bus.done), 32'd0);
        check("cancel_hi", bus.hi, m_hi);
        check("cancel_lo", bus.lo, m_lo);
        @(posedge clk); #1;
        check("cancel_done2", 32'(bus.done), 32'd0);
        cancel = 1'b1;
        bus.issue = 1'b1; bus.mul_func = 4'd5; bus.op_a = 32'hABCD;
        @(posedge clk); #1;
        cancel = 1'b0; bus.issue = 1'b0; bus.mul_func = 4'd0;
        check("cancel_idle_hi", bus.hi, m_hi);
`endif

        for (int i = 0; i < 30; i++) begin
            f = 4'($urandom_range(1, 10));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 9));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            eh = m_hi; el = m_lo;
            model_op(f, a, b, eh, el);
            run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, eh, el);
            m_hi = eh; m_lo = el;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
